stream_interface: RTL and testbench

- Parametrised successor of the host-facing data interface: a single input word stream carrying headers, op words and data words.
- Decodes headers, pairs each op word with its data word, and issues commands to the controller over a valid/ready handshake.
- Buffers controller results in an output FIFO with full backpressure on input and output; adds sticky error reporting.

---
 rtl/stream_pkg.sv | 29 ++
 rtl/stream_fifo.sv | 84 ++++++++
 rtl/stream_interface.sv | 174 +++++++++++++++++
 tb/tb_stream_interface.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// ============================================================================
// stream_pkg : shared header types, FSM encoding and error-bit indices
// Revision   : 1.0
// ============================================================================
`default_nettype none

package stream_pkg;

    localparam int HDR_TYPE_LSB = 16;
    localparam int HDR_TYPE_W   = 4;

    localparam logic [HDR_TYPE_W-1:0] HDR_OPCNT  = 4'd0;
    localparam logic [HDR_TYPE_W-1:0] HDR_OUTCNT = 4'd1;
    localparam logic [HDR_TYPE_W-1:0] HDR_SIZE   = 4'd2;
    localparam logic [HDR_TYPE_W-1:0] HDR_CLRERR = 4'd3;

    localparam int ERR_HDR = 0;
    localparam int ERR_OVF = 1;
    localparam int ERR_W   = 2;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_OP   = 2'd1,
        ST_DATA = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/stream_fifo.sv
// ============================================================================
// stream_fifo : result FIFO with registered first-word-fall-through head
// Revision    : 1.0
// ============================================================================
`default_nettype none

module stream_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              empty_o,
    output logic              overflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              valid_q, valid_d;

    logic w_full;
    logic w_push_ok;
    logic w_pop_ok;

    assign w_full    = (count_q == CW'(FIFO_DEPTH));
    assign w_pop_ok  = pop_i && valid_q;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = push_i && (!w_full || w_pop_ok);

    assign overflow_o = push_i && w_full && !w_pop_ok;
    assign rdata_o    = head_q;
    assign empty_o    = !valid_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(w_push_ok);
        rd_ptr_d = rd_ptr_q + AW'(w_pop_ok);
        count_d  = count_q + CW'(w_push_ok) - CW'(w_pop_ok);
        valid_d  = (count_d != '0);
        head_d   = head_q;
        if (count_d != '0) begin
            // Bypass the array when the only remaining entry is the one being written.
            if ((count_q - CW'(w_pop_ok)) == '0) begin
                head_d = wdata_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream_interface.sv
// ============================================================================
// stream_interface : header/op/data stream decoder, command issue, result FIFO
// Revision         : 1.0
// ============================================================================
`default_nettype none

module stream_interface
    import stream_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                CNT_W      = 16,
    parameter int                SIZE_W     = 9,
    parameter logic [SIZE_W-1:0] SIZE_RST   = 9'h04F,
    parameter int                FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] cmd_op,
    output logic [DATA_W-1:0] cmd_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [SIZE_W-1:0] size,
    input  logic [DATA_W-1:0] res_data,
    input  logic              res_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_count_valid,
    output logic [ERR_W-1:0]  err,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] op_tmp_q, op_tmp_d;
    logic [DATA_W-1:0] cmd_op_q, cmd_op_d;
    logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;
    logic              out_count_valid_q, out_count_valid_d;
    logic [ERR_W-1:0]  err_q, err_d;

    logic                  w_accept;
    logic [HDR_TYPE_W-1:0] w_hdr_type;
    logic                  w_fifo_empty;
    logic                  w_fifo_ovf;

    // A stalled command blocks input; a command taken this cycle frees the slot.
    assign in_ready   = clear_n && !(cmd_valid_q && !cmd_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_hdr_type = in_data[HDR_TYPE_LSB +: HDR_TYPE_W];

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        op_tmp_d          = op_tmp_q;
        cmd_op_d          = cmd_op_q;
        cmd_data_d        = cmd_data_q;
        cmd_valid_d       = cmd_valid_q;
        size_d            = size_q;
        out_count_d       = out_count_q;
        out_count_valid_d = 1'b0;
        err_d             = err_q;

        if (cmd_ready) begin
            cmd_valid_d = 1'b0;
        end

        if (w_accept) begin
            case (state_q)
                ST_HDR: begin
                    case (w_hdr_type)
                        HDR_OPCNT: begin
                            cnt_d = in_data[CNT_W-1:0];
                            if (in_data[CNT_W-1:0] != '0) begin
                                state_d = ST_OP;
                            end
                        end
                        HDR_OUTCNT: begin
                            out_count_d       = in_data[CNT_W-1:0];
                            out_count_valid_d = 1'b1;
                        end
                        HDR_SIZE: begin
                            size_d = in_data[SIZE_W-1:0];
                        end
                        HDR_CLRERR: begin
                            err_d = '0;
                        end
                        default: begin
                            err_d[ERR_HDR] = 1'b1;
                        end
                    endcase
                end
                ST_OP: begin
                    op_tmp_d = in_data;
                    state_d  = ST_DATA;
                end
                ST_DATA: begin
                    cmd_op_d    = op_tmp_q;
                    cmd_data_d  = in_data;
                    cmd_valid_d = 1'b1;
                    cnt_d       = cnt_q - CNT_W'(1);
                    state_d     = (cnt_q == CNT_W'(1)) ? ST_HDR : ST_OP;
                end
                default: begin
                    state_d = ST_HDR;
                end
            endcase
        end

        // Overflow is applied after a clear so a coincident overflow is not lost.
        if (w_fifo_ovf) begin
            err_d[ERR_OVF] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q           <= ST_HDR;
            cnt_q             <= '0;
            op_tmp_q          <= '0;
            cmd_op_q          <= '0;
            cmd_data_q        <= '0;
            cmd_valid_q       <= 1'b0;
            size_q            <= SIZE_RST;
            out_count_q       <= '0;
            out_count_valid_q <= 1'b0;
            err_q             <= '0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            op_tmp_q          <= op_tmp_d;
            cmd_op_q          <= cmd_op_d;
            cmd_data_q        <= cmd_data_d;
            cmd_valid_q       <= cmd_valid_d;
            size_q            <= size_d;
            out_count_q       <= out_count_d;
            out_count_valid_q <= out_count_valid_d;
            err_q             <= err_d;
        end
    end

    stream_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .clear_n    (clear_n),
        .push_i     (res_valid),
        .wdata_i    (res_data),
        .pop_i      (out_ready),
        .rdata_o    (out_data),
        .empty_o    (w_fifo_empty),
        .overflow_o (w_fifo_ovf)
    );

    assign out_valid       = !w_fifo_empty;
    assign cmd_op          = cmd_op_q;
    assign cmd_data        = cmd_data_q;
    assign cmd_valid       = cmd_valid_q;
    assign size            = size_q;
    assign out_count       = out_count_q;
    assign out_count_valid = out_count_valid_q;
    assign err             = err_q;
    assign busy            = (state_q != ST_HDR) || cmd_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_interface.sv
// ============================================================================
// tb_stream_interface : directed self-checking bench for stream_interface
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_stream_interface;

    localparam int DATA_W     = 32;
    localparam int CNT_W      = 16;
    localparam int SIZE_W     = 9;
    localparam int FIFO_DEPTH = 8;

    logic              clk = 1'b0;
    logic              clear_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [SIZE_W-1:0] size;
    logic [DATA_W-1:0] res_data;
    logic              res_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
    logic              out_count_valid;
    logic [1:0]        err;
    logic              busy;

    stream_interface #(
        .DATA_W     (DATA_W),
        .CNT_W      (CNT_W),
        .SIZE_W     (SIZE_W),
        .SIZE_RST   (9'h04F),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_dut (
        .clk             (clk),
        .clear_n         (clear_n),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .cmd_op          (cmd_op),
        .cmd_data        (cmd_data),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .size            (size),
        .res_data        (res_data),
        .res_valid       (res_valid),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_count       (out_count),
        .out_count_valid (out_count_valid),
        .err             (err),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Handshakes observed on the falling edge; inputs only change just after rising edges.
    logic [31:0] mon_op[$];
    logic [31:0] mon_data[$];
    int          ocv_total = 0;

    always @(negedge clk) begin
        if (clear_n && cmd_valid && cmd_ready) begin
            mon_op.push_back(cmd_op);
            mon_data.push_back(cmd_data);
        end
        if (out_count_valid) begin
            ocv_total++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        int  n    = 0;
        bit  done = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        while (!done && n < 100) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            else          n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted, got 0 required 1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int o;
        int stall;

        clear_n   = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        cmd_ready = 1'b1;
        res_data  = '0;
        res_valid = 1'b0;
        out_ready = 1'b0;

        repeat (2) tick();
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_size",      32'(size),      32'h04F);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        clear_n = 1'b1;
        tick();
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Two commands, controller always ready
        base = mon_op.size();
        send(32'h0000_0002);
        send(32'h3);
        send(32'hAAAA);
        check("t1_busy_mid", 32'(busy), 32'd1);
        send(32'h2);
        send(32'h5555);
        repeat (3) tick();
        check("t1_ncmd",  32'(mon_op.size() - base), 32'd2);
        check("t1_op0",   mon_op[base],     32'h3);
        check("t1_data0", mon_data[base],   32'hAAAA);
        check("t1_op1",   mon_op[base+1],   32'h2);
        check("t1_data1", mon_data[base+1], 32'h5555);
        check("t1_busy",  32'(busy), 32'd0);

        // Configuration headers
        o = ocv_total;
        send(32'h0001_0010);
        repeat (3) tick();
        check("t2_out_count", 32'(out_count), 32'd16);
        check("t2_ocv_pulse", 32'(ocv_total - o), 32'd1);
        send(32'h0002_0123);
        tick();
        check("t2_size", 32'(size), 32'h123);
        send(32'h0007_0000);
        tick();
        check("t2_err_hdr", 32'(err), 32'd1);
        check("t2_busy",    32'(busy), 32'd0);
        send(32'h0003_0000);
        tick();
        check("t2_err_clr", 32'(err), 32'd0);

        // Controller stall
        cmd_ready = 1'b0;
        base = mon_op.size();
        send(32'h0000_0002);
        send(32'h3);
        send(32'hAAAA);
        in_data  = 32'h2;
        in_valid = 1'b1;
        stall    = 0;
        repeat (5) begin
            @(negedge clk);
            if (!in_ready) stall++;
        end
        check("t3_stall",     32'(stall), 32'd5);
        check("t3_cmd_held",  32'(cmd_valid), 32'd1);
        check("t3_none_yet",  32'(mon_op.size() - base), 32'd0);
        @(posedge clk);
        #1;
        cmd_ready = 1'b1;
        send(32'h2);
        send(32'h5555);
        repeat (3) tick();
        check("t3_ncmd",  32'(mon_op.size() - base), 32'd2);
        check("t3_op0",   mon_op[base],     32'h3);
        check("t3_data0", mon_data[base],   32'hAAAA);
        check("t3_op1",   mon_op[base+1],   32'h2);
        check("t3_data1", mon_data[base+1], 32'h5555);

        // FIFO overflow and in-order drain
        out_ready = 1'b0;
        check("t4_empty", 32'(out_valid), 32'd0);
        for (int i = 0; i < 9; i++) begin
            res_data  = 32'h100 + 32'(i);
            res_valid = 1'b1;
            tick();
            if (i == 0) check("t4_fwft", 32'(out_valid), 32'd1);
        end
        res_valid = 1'b0;
        tick();
        check("t4_err_ovf", 32'(err), 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t4_pop", out_data, 32'h100 + 32'(i));
        end
        @(negedge clk);
        check("t4_drained", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(32'h0003_0000);
        tick();
        check("t4_err_clr", 32'(err), 32'd0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            res_data  = 32'h200 + 32'(i);
            res_valid = 1'b1;
            tick();
        end
        res_data  = 32'h208;
        out_ready = 1'b1;
        tick();
        res_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        check("t5_no_ovf", 32'(err), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t5_pop", out_data, 32'h201 + 32'(i));
        end
        @(negedge clk);
        check("t5_drained", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset in the middle of a command with results buffered
        for (int i = 0; i < 3; i++) begin
            res_data  = 32'h300 + 32'(i);
            res_valid = 1'b1;
            tick();
        end
        res_valid = 1'b0;
        send(32'h0002_0055);
        send(32'h0000_0002);
        send(32'h7);
        check("t6_busy_pre", 32'(busy), 32'd1);
        check("t6_size_pre", 32'(size), 32'h055);
        check("t6_ov_pre",   32'(out_valid), 32'd1);
        clear_n = 1'b0;
        #1;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_cmd_valid", 32'(cmd_valid), 32'd0);
        check("t6_size",      32'(size),      32'h04F);
        check("t6_busy",      32'(busy),      32'd0);
        check("t6_in_ready",  32'(in_ready),  32'd0);
        tick();
        tick();
        clear_n = 1'b1;
        tick();
        base = mon_op.size();
        send(32'h0000_0001);
        send(32'h9);
        send(32'h1234);
        repeat (3) tick();
        check("t6_ncmd",  32'(mon_op.size() - base), 32'd1);
        check("t6_op",    mon_op[base],   32'h9);
        check("t6_data",  mon_data[base], 32'h1234);
        check("t6_idle",  32'(busy), 32'd0);
        check("t6_empty", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
